// File: rtl/axis_level_trigger_pkg.sv
// Shared constants and types for the AXI4-Stream level trigger: trigger bit
// positions, sample lane positions and the detector state encoding.
package axis_level_trigger_pkg;

    localparam int TRIG_CH1_RISE = 0;
    localparam int TRIG_CH1_FALL = 1;
    localparam int TRIG_CH2_RISE = 2;
    localparam int TRIG_CH2_FALL = 3;
    localparam int TRIG_FORCE    = 4;

    localparam int SAMPLE_W = 16;
    localparam int BOUND_W  = 18;
    localparam int CH1_LSB  = 16;
    localparam int CH2_LSB  = 0;

    typedef enum logic {
        DET_DISARMED = 1'b0,
        DET_ARMED    = 1'b1
    } det_state_e;

    typedef enum logic {
        POL_RISING  = 1'b0,
        POL_FALLING = 1'b1
    } det_pol_e;

    // Keeps the SAMPLE_BITS most significant bits of a 16-bit sample.
    function automatic logic [15:0] sample_mask(input int unsigned bits);
        logic [15:0] mask;
        mask = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            mask[i] = (i >= (16 - int'(bits)));
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_level_trigger_level_crossing_detector.sv
// Two-state hysteresis level-crossing detector for one channel and one direction.
// The fire output is combinational and valid for the beat presented this cycle.
module level_crossing_detector
    import axis_level_trigger_pkg::*;
#(
    parameter det_pol_e POLARITY = POL_RISING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        beat,
    input  logic [15:0] sample,
    input  logic [15:0] level,
    input  logic [15:0] hyst,
    output logic        fire
);

    det_state_e                state_r;
    logic signed [BOUND_W-1:0] sample_ext_s;
    logic signed [BOUND_W-1:0] level_ext_s;
    logic signed [BOUND_W-1:0] hyst_ext_s;
    logic signed [BOUND_W-1:0] bound_s;
    logic                      arm_cond_s;
    logic                      fire_cond_s;

    // Widen to 18 bits so level +/- hyst can never wrap back into sample range.
    always_comb begin
        sample_ext_s = {{2{sample[15]}}, sample};
        level_ext_s  = {{2{level[15]}}, level};
        hyst_ext_s   = {2'b00, hyst};
        bound_s      = level_ext_s;
        arm_cond_s   = 1'b0;
        fire_cond_s  = 1'b0;
        if (POLARITY == POL_RISING) begin
            bound_s     = level_ext_s - hyst_ext_s;
            arm_cond_s  = (sample_ext_s < bound_s);
            fire_cond_s = (sample_ext_s >= level_ext_s);
        end else begin
            bound_s     = level_ext_s + hyst_ext_s;
            arm_cond_s  = (sample_ext_s > bound_s);
            fire_cond_s = (sample_ext_s <= level_ext_s);
        end
    end

    assign fire = beat & ~clear & (state_r == DET_ARMED) & fire_cond_s;

    // Arm/fire state; clear wins, and state only moves on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DET_DISARMED;
        end else if (clear) begin
            state_r <= DET_DISARMED;
        end else if (beat) begin
            case (state_r)
                DET_DISARMED: state_r <= arm_cond_s ? DET_ARMED : DET_DISARMED;
                DET_ARMED:    state_r <= fire_cond_s ? DET_DISARMED : DET_ARMED;
                default:      state_r <= DET_DISARMED;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: rtl/axis_level_trigger.sv
// AXI4-Stream register slice that tags each two-channel beat with level
// crossing and software trigger flags for a downstream tlast injector.
module axis_level_trigger
    import axis_level_trigger_pkg::*;
#(
    parameter int SAMPLE_BITS = 14
) (
    input  logic        stream_clk,
    input  logic        stream_resetn,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] trigger,
    input  logic [15:0] ch1_level,
    input  logic [15:0] ch2_level,
    input  logic [15:0] ch1_hyst,
    input  logic [15:0] ch2_hyst,
    input  logic        detector_clear,
    input  logic        force_trigger
);

    localparam logic [15:0] SAMPLE_MASK = sample_mask(SAMPLE_BITS);

    logic        rst_done_r;
    logic        m_tvalid_r;
    logic [31:0] m_tdata_r;
    logic [31:0] trigger_r;
    logic        force_pend_r;
    logic        accept_s;
    logic [15:0] ch1_sample_s;
    logic [15:0] ch2_sample_s;
    logic [3:0]  fire_s;
    logic [31:0] trig_next_s;

    assign s_tready     = rst_done_r & (~m_tvalid_r | m_tready);
    assign accept_s     = s_tvalid & s_tready;
    assign ch1_sample_s = s_tdata[CH1_LSB +: SAMPLE_W] & SAMPLE_MASK;
    assign ch2_sample_s = s_tdata[CH2_LSB +: SAMPLE_W] & SAMPLE_MASK;
    assign m_tdata      = m_tdata_r;
    assign m_tvalid     = m_tvalid_r;
    assign trigger      = trigger_r;

    level_crossing_detector #(.POLARITY(POL_RISING)) u_ch1_rise (
        .clk(stream_clk), .rst_n(stream_resetn), .clear(detector_clear), .beat(accept_s),
        .sample(ch1_sample_s), .level(ch1_level), .hyst(ch1_hyst), .fire(fire_s[0])
    );
    level_crossing_detector #(.POLARITY(POL_FALLING)) u_ch1_fall (
        .clk(stream_clk), .rst_n(stream_resetn), .clear(detector_clear), .beat(accept_s),
        .sample(ch1_sample_s), .level(ch1_level), .hyst(ch1_hyst), .fire(fire_s[1])
    );
    level_crossing_detector #(.POLARITY(POL_RISING)) u_ch2_rise (
        .clk(stream_clk), .rst_n(stream_resetn), .clear(detector_clear), .beat(accept_s),
        .sample(ch2_sample_s), .level(ch2_level), .hyst(ch2_hyst), .fire(fire_s[2])
    );
    level_crossing_detector #(.POLARITY(POL_FALLING)) u_ch2_fall (
        .clk(stream_clk), .rst_n(stream_resetn), .clear(detector_clear), .beat(accept_s),
        .sample(ch2_sample_s), .level(ch2_level), .hyst(ch2_hyst), .fire(fire_s[3])
    );

    // Trigger vector for the beat being accepted this cycle.
    always_comb begin
        trig_next_s                = 32'h0000_0000;
        trig_next_s[TRIG_CH1_RISE] = fire_s[0];
        trig_next_s[TRIG_CH1_FALL] = fire_s[1];
        trig_next_s[TRIG_CH2_RISE] = fire_s[2];
        trig_next_s[TRIG_CH2_FALL] = fire_s[3];
        trig_next_s[TRIG_FORCE]    = force_pend_r | force_trigger;
    end

    // Gates acceptance for one cycle after reset release.
    always_ff @(posedge stream_clk or negedge stream_resetn) begin
        if (!stream_resetn) begin
            rst_done_r <= 1'b0;
        end else begin
            rst_done_r <= 1'b1;
        end
    end

    // Register slice; trigger is zeroed whenever the slice empties.
    always_ff @(posedge stream_clk or negedge stream_resetn) begin
        if (!stream_resetn) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 32'h0000_0000;
            trigger_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= s_tdata;
            trigger_r  <= trig_next_s;
        end else if (m_tready) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= m_tdata_r;
            trigger_r  <= 32'h0000_0000;
        end else begin
            m_tvalid_r <= m_tvalid_r;
            m_tdata_r  <= m_tdata_r;
            trigger_r  <= trigger_r;
        end
    end

    // Sticky software trigger; survives detector_clear, consumed by the next beat.
    always_ff @(posedge stream_clk or negedge stream_resetn) begin
        if (!stream_resetn) begin
            force_pend_r <= 1'b0;
        end else if (accept_s) begin
            force_pend_r <= 1'b0;
        end else if (force_trigger) begin
            force_pend_r <= 1'b1;
        end else begin
            force_pend_r <= force_pend_r;
        end
    end

endmodule

// File: tb/tb_axis_level_trigger.sv
// Directed bench for axis_level_trigger: level crossings, hysteresis,
// backpressure, software trigger and mid-stream reset.
module tb_axis_level_trigger;

    logic        stream_clk = 1'b0;
    logic        stream_resetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] trigger;
    logic [15:0] ch1_level, ch2_level, ch1_hyst, ch2_hyst;
    logic        detector_clear;
    logic        force_trigger;

    int checks = 0;
    int errors = 0;

    axis_level_trigger #(.SAMPLE_BITS(14)) dut (
        .stream_clk(stream_clk), .stream_resetn(stream_resetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .trigger(trigger),
        .ch1_level(ch1_level), .ch2_level(ch2_level),
        .ch1_hyst(ch1_hyst), .ch2_hyst(ch2_hyst),
        .detector_clear(detector_clear), .force_trigger(force_trigger)
    );

    always #5 stream_clk = ~stream_clk;

    // One accepted beat with m_tready high; checks the slice output one cycle later.
    task automatic beat(input int c1, input int c2, input logic frc, input logic clr,
                        input logic [31:0] exp_trig, input string name);
        logic [31:0] d;
        d = {c1[15:0], c2[15:0]};
        @(negedge stream_clk);
        s_tdata = d; s_tvalid = 1'b1; force_trigger = frc; detector_clear = clr;
        @(posedge stream_clk); #1;
        force_trigger = 1'b0; detector_clear = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== d || trigger !== exp_trig) begin
            errors++;
            $display("FAIL %s: m_tvalid=%0b m_tdata=%h trigger=%h, expected m_tvalid=1 m_tdata=%h trigger=%h",
                     name, m_tvalid, m_tdata, trigger, d, exp_trig);
        end
    endtask

    task automatic clear_dets();
        @(negedge stream_clk);
        s_tvalid = 1'b0; detector_clear = 1'b1;
        @(negedge stream_clk);
        detector_clear = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || trigger !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: m_tvalid=%0b m_tdata=%h trigger=%h, expected 0 0 0",
                     m_tvalid, m_tdata, trigger);
        end
        @(negedge stream_clk);
        stream_resetn = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: s_tready=%0b, expected 0", s_tready);
        end
        @(posedge stream_clk); #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: s_tready=%0b, expected 1", s_tready);
        end
    endtask

    task automatic test_rising();
        clear_dets();
        ch1_level = 16'd1000; ch1_hyst = 16'd100;
        beat(800, 0, 1'b0, 1'b0, 32'h0, "rise_800");
        beat(950, 0, 1'b0, 1'b0, 32'h0, "rise_950");
        beat(1000, 0, 1'b0, 1'b0, 32'h1, "rise_1000");
        beat(1200, 0, 1'b0, 1'b0, 32'h0, "rise_1200");
        // 1200 armed the ch1 falling detector, so 800 fires it.
        beat(800, 0, 1'b0, 1'b0, 32'h2, "rise_800_again");
        beat(1000, 0, 1'b0, 1'b0, 32'h1, "rise_1000_again");
    endtask

    task automatic test_no_rearm();
        clear_dets();
        beat(800, 0, 1'b0, 1'b0, 32'h0, "norearm_arm");
        beat(1000, 0, 1'b0, 1'b0, 32'h1, "norearm_fire");
        beat(950, 0, 1'b0, 1'b0, 32'h0, "norearm_950a");
        beat(1050, 0, 1'b0, 1'b0, 32'h0, "norearm_1050a");
        beat(950, 0, 1'b0, 1'b0, 32'h0, "norearm_950b");
        beat(1050, 0, 1'b0, 1'b0, 32'h0, "norearm_1050b");
    endtask

    task automatic test_hyst_zero();
        clear_dets();
        ch1_level = 16'd1000; ch1_hyst = 16'd0;
        beat(1000, 0, 1'b0, 1'b0, 32'h0, "hyst0_at_level");
        beat(996, 0, 1'b0, 1'b0, 32'h0, "hyst0_below");
        beat(1000, 0, 1'b0, 1'b0, 32'h1, "hyst0_fire");
        ch1_hyst = 16'd100;
    endtask

    task automatic test_falling();
        clear_dets();
        ch2_level = 16'hFE0C; ch2_hyst = 16'd0;
        beat(0, -400, 1'b0, 1'b0, 32'h0, "fall_m400");
        beat(0, -500, 1'b0, 1'b0, 32'h8, "fall_m500");
        ch2_level = 16'd0;
    endtask

    task automatic test_bounds();
        clear_dets();
        ch1_level = 16'h8000; ch1_hyst = 16'd100;
        beat(-32768, 0, 1'b0, 1'b0, 32'h0, "bound_min");
        beat(0, 0, 1'b0, 1'b0, 32'h0, "bound_zero");
        beat(1000, 0, 1'b0, 1'b0, 32'h0, "bound_1000");
    endtask

    task automatic test_mask();
        clear_dets();
        ch1_level = 16'd1002; ch1_hyst = 16'd0;
        beat(800, 0, 1'b0, 1'b0, 32'h0, "mask_arm");
        beat(1003, 0, 1'b0, 1'b0, 32'h0, "mask_1003");
        beat(1004, 0, 1'b0, 1'b0, 32'h1, "mask_1004");
        ch1_level = 16'd1000; ch1_hyst = 16'd100;
    endtask

    task automatic test_backpressure();
        clear_dets();
        beat(800, 0, 1'b0, 1'b0, 32'h0, "bp_arm");
        @(negedge stream_clk);
        s_tdata = {16'd1000, 16'd0}; s_tvalid = 1'b1;
        @(posedge stream_clk); #1;
        m_tready = 1'b0;
        s_tdata = {16'd1200, 16'd0};
        for (int i = 0; i < 5; i++) begin
            @(posedge stream_clk); #1;
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== {16'd1000, 16'd0} || trigger !== 32'h1 || s_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: m_tvalid=%0b m_tdata=%h trigger=%h s_tready=%0b, expected 1 %h 00000001 0",
                         i, m_tvalid, m_tdata, trigger, s_tready, {16'd1000, 16'd0});
            end
        end
        @(negedge stream_clk);
        m_tready = 1'b1;
        @(posedge stream_clk); #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== {16'd1200, 16'd0} || trigger !== 32'h0) begin
            errors++;
            $display("FAIL bp_next: m_tvalid=%0b m_tdata=%h trigger=%h, expected 1 %h 00000000",
                     m_tvalid, m_tdata, trigger, {16'd1200, 16'd0});
        end
        @(negedge stream_clk);
        s_tvalid = 1'b0;
        @(posedge stream_clk); #1;
        checks++;
        if (m_tvalid !== 1'b0 || trigger !== 32'h0) begin
            errors++;
            $display("FAIL bp_drain: m_tvalid=%0b trigger=%h, expected 0 00000000", m_tvalid, trigger);
        end
    endtask

    task automatic test_force();
        clear_dets();
        @(negedge stream_clk);
        s_tvalid = 1'b0; force_trigger = 1'b1;
        @(negedge stream_clk);
        force_trigger = 1'b0;
        beat(0, 0, 1'b0, 1'b0, 32'h10, "force_first");
        beat(0, 0, 1'b0, 1'b0, 32'h0, "force_second");
        beat(0, 0, 1'b0, 1'b0, 32'h0, "force_third");
        @(negedge stream_clk);
        s_tvalid = 1'b0; force_trigger = 1'b1; detector_clear = 1'b1;
        @(negedge stream_clk);
        force_trigger = 1'b0; detector_clear = 1'b0;
        beat(0, 0, 1'b0, 1'b0, 32'h10, "force_kept_by_clear");
        beat(800, 0, 1'b0, 1'b0, 32'h0, "force_arm");
        beat(1000, 0, 1'b1, 1'b1, 32'h10, "force_with_clear");
        beat(1000, 0, 1'b0, 1'b0, 32'h0, "force_after_clear");
    endtask

    task automatic test_reset_mid();
        clear_dets();
        beat(800, 0, 1'b0, 1'b0, 32'h0, "rstmid_arm");
        @(negedge stream_clk);
        m_tready = 1'b0; s_tdata = {16'd1200, 16'd0}; s_tvalid = 1'b1;
        #2 stream_resetn = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || trigger !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: m_tvalid=%0b m_tdata=%h trigger=%h, expected 0 0 0",
                     m_tvalid, m_tdata, trigger);
        end
        @(negedge stream_clk);
        stream_resetn = 1'b1; m_tready = 1'b1;
        @(posedge stream_clk); #1;
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first_cycle: m_tvalid=%0b, expected 0", m_tvalid);
        end
        beat(1200, 0, 1'b0, 1'b0, 32'h0, "rstmid_1200");
    endtask

    initial begin
        stream_resetn = 1'b0;
        s_tdata = 32'h0; s_tvalid = 1'b0; m_tready = 1'b1;
        ch1_level = 16'd1000; ch1_hyst = 16'd100;
        ch2_level = 16'd0; ch2_hyst = 16'd0;
        detector_clear = 1'b0; force_trigger = 1'b0;
        repeat (2) @(posedge stream_clk);
        test_reset();
        test_rising();
        test_no_rearm();
        test_hyst_zero();
        test_falling();
        test_bounds();
        test_mask();
        test_backpressure();
        test_force();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_level_trigger.md
AXIS_LEVEL_TRIGGER -- requirements
Module: axis_level_trigger

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 14: significant MSB-aligned bits per 16-bit sample; LSBs below them are forced to zero before comparison.
REQ-002 SHALL have port stream_clk  in  1  stream clock; the only clock.
REQ-003 SHALL have port stream_resetn  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port s_tdata  in  32  ch1 sample [31:16], ch2 sample [15:0], signed two's complement.
REQ-005 SHALL have ports s_tvalid in 1 and s_tready out 1: AXI4-Stream slave handshake.
REQ-006 SHALL have ports m_tdata out 32, m_tvalid out 1 and m_tready in 1: AXI4-Stream master; m_tdata is s_tdata delayed, unmodified.
REQ-007 SHALL have port trigger  out  32  per-beat trigger vector aligned with m_tdata; feeds the downstream trigger/tlast injector.
REQ-008 SHALL have ports ch1_level and ch2_level, each in 16 signed: threshold per channel.
REQ-009 SHALL have ports ch1_hyst and ch2_hyst, each in 16 unsigned: hysteresis per channel.
REQ-010 SHALL have port detector_clear  in  1  synchronous pulse; disarms all detectors.
REQ-011 SHALL have port force_trigger  in  1  synchronous pulse; software trigger request.

Function
REQ-012 SHALL implement one register slice with s_tready = ~m_tvalid | m_tready; an accepted beat appears on m_tdata/m_tvalid exactly 1 cycle later.
REQ-013 SHALL hold m_tdata and trigger stable while m_tvalid=1 and m_tready=0.
REQ-014 SHALL define trigger bits as: [0] ch1 rising, [1] ch1 falling, [2] ch2 rising, [3] ch2 falling, [4] forced; [31:5] tied to 0.
REQ-015 SHALL drive trigger to 0 whenever m_tvalid=0.
REQ-016 SHALL give each of the 4 detectors two states, DISARMED and ARMED, and SHALL update them only on accepted beats (s_tvalid & s_tready).
REQ-017 SHALL move a rising detector DISARMED->ARMED when sample < level - hyst, and SHALL fire it (set its bit for that beat) and return it to DISARMED when it is ARMED and sample >= level.
REQ-018 SHALL move a falling detector DISARMED->ARMED when sample > level + hyst, and SHALL fire it and return it to DISARMED when it is ARMED and sample <= level.
REQ-019 SHALL not allow a detector to arm and fire on the same beat; firing requires ARMED at the start of the beat.
REQ-020 SHALL compute level+/-hyst in 18-bit signed arithmetic with no wrap and no saturation; a bound outside the sample range means that detector can never arm.
REQ-021 SHALL, with hyst=0, arm a rising detector strictly below level and fire it at or above level.
REQ-022 SHALL read thresholds combinationally on every beat; mid-stream changes take effect on the next accepted beat and do not alter detector state.
REQ-023 SHALL make force_trigger set a sticky pending flag; the next accepted beat carries bit[4]=1 and clears the flag; force_trigger in the same cycle as an accepted beat applies to that beat.
REQ-024 SHALL give detector_clear priority over arming and firing in the same cycle; that beat's detector bits are 0, and a pending force is kept.

Reset
REQ-025 SHALL, while stream_resetn=0, drive m_tvalid=0, m_tdata=0 and trigger=0, clear the pending-force flag and disarm all detectors, asynchronously.
REQ-026 SHALL discard the beat held in the slice when reset is asserted mid-stream.
REQ-027 SHALL release reset synchronously to stream_clk, with the first beat accepted at the earliest 1 cycle after deassertion.

Structure
REQ-028 SHALL place the trigger bit indices (0..4), the detector state encoding and the sample split positions in a shared package.
REQ-029 SHALL use one sub-module, level_crossing_detector (parameter for polarity), instantiated 4 times.

Verification
REQ-030 SHALL check: ch1_level=1000, hyst=100, ch1 samples 800,950,1000,1200 -> trigger[0]=1 only on the beat carrying 1000; ch1 samples 800,1000 -> trigger[0] on 1000 (armed by 800).
REQ-031 SHALL check: ch1_level=1000, hyst=100, ch1 samples 950,1050,950,1050 (never below 900) -> no trigger[0] after the first fire.
REQ-032 SHALL check: ch2_level=-500, hyst=0, ch2 samples -400,-500 -> trigger[3]=1 on -500; bits 0..2 stay 0.
REQ-033 SHALL check: m_tready held low 5 cycles while a firing beat is in the slice -> m_tdata and trigger stable, s_tready=0, no beat lost or duplicated.
REQ-034 SHALL check: force_trigger pulsed with s_tvalid=0, then 3 beats -> bit[4] only on the first beat; force_trigger pulsed with detector_clear -> bit[4]=1 and bits[3:0]=0.
REQ-035 SHALL check: reset asserted with ch1 rising detector ARMED and a beat pending -> m_tvalid=0 immediately; after release, sample 1200 at level 1000 -> no trigger.
